// File: rtl/sargantana_icache_refill.sv
// rtl/sargantana_icache_refill.sv - instruction cache line refill controller
// Accepts a miss, fetches the line beat by beat, picks a victim way and writes the data memory.
module sargantana_icache_refill #(
  parameter int ICACHE_N_WAY = 4,
  parameter int SET_WIDHT    = 256,
  parameter int ADDR_WIDHT   = 6,
  parameter int BEAT_WIDTH   = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            miss_valid_i,
  output logic                            miss_ready_o,
  input  logic [ADDR_WIDHT-1:0]           miss_idx_i,
  input  logic [ICACHE_N_WAY-1:0]         valid_bits_i,
  input  logic                            flush_i,
  output logic                            mem_req_valid_o,
  input  logic                            mem_req_ready_i,
  output logic [ADDR_WIDHT-1:0]           mem_req_idx_o,
  input  logic                            mem_rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0]           mem_rsp_data_i,
  output logic [ICACHE_N_WAY-1:0]         req_o,
  output logic                            we_o,
  output logic [ADDR_WIDHT-1:0]           addr_o,
  output logic [SET_WIDHT-1:0]            data_o,
  output logic                            done_o,
  output logic [$clog2(ICACHE_N_WAY)-1:0] done_way_o,
  output logic                            busy_o
);

  localparam int N_BEATS = SET_WIDHT / BEAT_WIDTH;
  localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int WW      = $clog2(ICACHE_N_WAY);

  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

  state_t                 state_q, state_d;
  logic [SET_WIDHT-1:0]   line_q;
  logic [ADDR_WIDHT-1:0]  idx_q;
  logic [CW-1:0]          beat_q;
  logic                   drop_q;
  logic [WW-1:0]          rr_q;
  logic [WW-1:0]          victim_q;

  logic                   accept;
  logic                   handshake;
  logic                   last_beat;
  logic                   all_valid;
  logic [WW-1:0]          inv_way;
  logic [WW-1:0]          victim_d;

  assign accept    = (state_q == IDLE) && miss_valid_i && !flush_i;
  assign handshake = (state_q == REQ) && mem_req_ready_i;
  assign last_beat = (state_q == FILL) && mem_rsp_valid_i && (beat_q == CW'(N_BEATS - 1));

  // Scan downwards so the lowest-index invalid way wins.
  always_comb begin
    all_valid = 1'b1;
    inv_way   = '0;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (!valid_bits_i[i]) begin
        all_valid = 1'b0;
        inv_way   = WW'(i);
      end
    end
    victim_d = all_valid ? rr_q : inv_way;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    req_o           = '0;
    we_o            = 1'b0;
    done_o          = 1'b0;
    done_way_o      = '0;
    busy_o          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (accept) state_d = REQ;
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (handshake)    state_d = FILL;
        else if (flush_i) state_d = IDLE;
      end
      FILL: begin
        // A flush arriving with the final beat must also suppress the write.
        if (last_beat) state_d = (drop_q || flush_i) ? IDLE : WRITE;
      end
      WRITE: begin
        req_o[victim_q] = 1'b1;
        we_o            = 1'b1;
        done_o          = 1'b1;
        done_way_o      = victim_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q   <= '0;
      idx_q    <= '0;
      beat_q   <= '0;
      drop_q   <= 1'b0;
      rr_q     <= '0;
      victim_q <= '0;
    end else begin
      if (accept) begin
        idx_q    <= miss_idx_i;
        victim_q <= victim_d;
        beat_q   <= '0;
        drop_q   <= 1'b0;
        if (all_valid) rr_q <= rr_q + 1'b1;
      end
      if ((handshake || state_q == FILL) && flush_i) drop_q <= 1'b1;
      if (state_q == FILL && mem_rsp_valid_i) begin
        line_q[beat_q*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rsp_data_i;
        beat_q                                  <= beat_q + 1'b1;
      end
    end
  end

  assign mem_req_idx_o = idx_q;
  assign addr_o        = idx_q;
  assign data_o        = line_q;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// tb/tb_sargantana_icache_refill.sv - scoreboard bench for the icache refill controller
module tb_sargantana_icache_refill;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         miss_valid_i = 1'b0;
  logic         miss_ready_o;
  logic [5:0]   miss_idx_i = '0;
  logic [3:0]   valid_bits_i = '0;
  logic         flush_i = 1'b0;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b0;
  logic [5:0]   mem_req_idx_o;
  logic         mem_rsp_valid_i = 1'b0;
  logic [63:0]  mem_rsp_data_i = '0;
  logic [3:0]   req_o;
  logic         we_o;
  logic [5:0]   addr_o;
  logic [255:0] data_o;
  logic         done_o;
  logic [1:0]   done_way_o;
  logic         busy_o;

  sargantana_icache_refill dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_idx_i(miss_idx_i), .valid_bits_i(valid_bits_i), .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_idx_o(mem_req_idx_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .req_o(req_o), .we_o(we_o),
    .addr_o(addr_o), .data_o(data_o), .done_o(done_o),
    .done_way_o(done_way_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]   way;
    logic [5:0]   idx;
    logic [255:0] line;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   rr = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   lat_chk = 1'b0;
  int   cur_way;
  logic [5:0] cur_idx;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    cyc++;
    if (miss_valid_i && miss_ready_o && !flush_i) acc_cyc = cyc;
    if (!done_o) check("req_outside_write", {252'd0, req_o}, 256'd0);
    if (done_o || we_o) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {254'd0, done_o, we_o}, 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("we", {255'd0, we_o}, 256'd1);
        check("done", {255'd0, done_o}, 256'd1);
        check("req_onehot", {252'd0, req_o}, 256'(4'b0001 << e.way));
        check("done_way", {254'd0, done_way_o}, {254'd0, e.way});
        check("addr", {250'd0, addr_o}, {250'd0, e.idx});
        check("data", data_o, e.line);
        if (lat_chk) check("miss_to_write_cycles", 256'(cyc - acc_cyc + 1), 256'd7);
      end
    end
  end

  task automatic start_miss(input logic [5:0] idx, input logic [3:0] vb);
    int n;
    int way;
    n = 0;
    while (!miss_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("miss_ready_timeout", 256'd0, 256'd1);
    way = -1;
    for (int i = 0; i < 4; i++) if (!vb[i] && way < 0) way = i;
    if (way < 0) begin
      way = rr;
      rr  = (rr + 1) % 4;
    end
    cur_way = way;
    cur_idx = idx;
    miss_valid_i = 1'b1;
    miss_idx_i   = idx;
    valid_bits_i = vb;
    tick();
    miss_valid_i = 1'b0;
    check("req_valid_after_miss", {255'd0, mem_req_valid_o}, 256'd1);
  endtask

  task automatic grant(input int stall);
    for (int k = 0; k < stall; k++) begin
      check("req_valid_stall", {255'd0, mem_req_valid_o}, 256'd1);
      check("req_idx_stable", {250'd0, mem_req_idx_o}, {250'd0, cur_idx});
      tick();
    end
    mem_req_ready_i = 1'b1;
    check("req_idx_grant", {250'd0, mem_req_idx_o}, {250'd0, cur_idx});
    tick();
    mem_req_ready_i = 1'b0;
    check("fill_after_grant", {254'd0, mem_req_valid_o, busy_o}, 256'd1);
  endtask

  task automatic beats(input logic [255:0] line, input int gap, input bit expect_write);
    exp_t e;
    if (expect_write) begin
      e.way  = 2'(cur_way);
      e.idx  = cur_idx;
      e.line = line;
      sb.push_back(e);
    end
    for (int b = 0; b < 4; b++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = line[b*64 +: 64];
      tick();
      mem_rsp_valid_i = 1'b0;
      if (b < 3) repeat (gap) tick();
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    logic [255:0] l;
    #2;
    check("rst_miss_ready", {255'd0, miss_ready_o}, 256'd1);
    check("rst_outs", {248'd0, busy_o, we_o, done_o, mem_req_valid_o, req_o}, 256'd0);
    check("rst_data", data_o, 256'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Basic refill: invalid way 2 chosen, minimum latency.
    lat_chk = 1'b1;
    start_miss(6'd5, 4'b1011);
    grant(0);
    beats({64'h4444444444444444, 64'h3333333333333333,
           64'h2222222222222222, 64'h1111111111111111}, 0, 1'b1);
    check("write_state", {254'd0, we_o, done_o}, 256'd3);
    lat_chk = 1'b0;

    // Round robin on all-valid sets, pointer untouched by invalid-way pick.
    for (int i = 0; i < 3; i++) begin
      start_miss(6'(10 + i), 4'b1111);
      grant(0);
      beats(rnd_line(), 0, 1'b1);
    end
    start_miss(6'd20, 4'b0111);
    grant(0);
    beats(rnd_line(), 0, 1'b1);
    start_miss(6'd21, 4'b1111);
    grant(0);
    beats(rnd_line(), 0, 1'b1);

    // Stalled grant and gapped beats.
    start_miss(6'd33, 4'b1110);
    grant(5);
    beats(rnd_line(), 2, 1'b1);

    // Flush in FILL after beat 1: remaining beats consumed, no write.
    start_miss(6'd9, 4'b1111);
    grant(0);
    l = rnd_line();
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = l[b*64 +: 64];
      tick();
    end
    mem_rsp_valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_fill_busy", {255'd0, busy_o}, 256'd1);
    for (int b = 2; b < 4; b++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = l[b*64 +: 64];
      tick();
    end
    mem_rsp_valid_i = 1'b0;
    check("flush_fill_idle", {254'd0, busy_o, miss_ready_o}, 256'd1);

    // Flush in REQ without grant.
    start_miss(6'd12, 4'b0000);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_req_idle", {253'd0, busy_o, mem_req_valid_o, miss_ready_o}, 256'd1);

    start_miss(6'd40, 4'b1111);
    grant(0);
    beats(rnd_line(), 1, 1'b1);

    // Asynchronous reset mid-FILL.
    start_miss(6'd50, 4'b0000);
    grant(0);
    l = rnd_line();
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = l[b*64 +: 64];
      tick();
    end
    mem_rsp_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_state", {251'd0, busy_o, miss_ready_o, we_o, done_o, mem_req_valid_o}, 256'd8);
    check("mid_rst_req", {252'd0, req_o}, 256'd0);
    check("mid_rst_data", data_o, 256'd0);
    rr = 0;
    tick();
    rst_i = 1'b0;
    start_miss(6'd51, 4'b1111);
    grant(0);
    beats(rnd_line(), 0, 1'b1);

    repeat (5) tick();
    check("sb_empty", 256'(sb.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/sargantana_icache_refill.md
# sargantana_icache_refill

Line-refill controller for the instruction cache, sitting directly upstream of the way data memory. It accepts a miss (set index plus current way valid bits), issues one line request to the next memory level, assembles the returned beats into a full set-wide line, selects a victim way, and performs the single-cycle write into the data memory. Its `req_o`/`we_o`/`addr_o`/`data_o` feed the data memory's write port through the cache's read/write arbiter.

## Interface
- `ICACHE_N_WAY`, 4: number of ways; power of two, ≥2.
- `SET_WIDHT`, 256: line width in bits; must equal the data memory set width.
- `ADDR_WIDHT`, 6: set index width.
- `BEAT_WIDTH`, 64: memory response beat width. `SET_WIDHT` must be a multiple of it. `N_BEATS = SET_WIDHT/BEAT_WIDTH` is ≥1.
- `clk_i` in 1: the single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `miss_valid_i` in 1: miss request.
- `miss_ready_o` out 1: controller idle and able to accept a miss.
- `miss_idx_i` in ADDR_WIDHT: set index of the miss.
- `valid_bits_i` in ICACHE_N_WAY: way valid bits of that set, sampled on acceptance.
- `flush_i` in 1: abort the current refill.
- `mem_req_valid_o` out 1: line request to memory.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_req_idx_o` out ADDR_WIDHT: latched set index.
- `mem_rsp_valid_i` in 1: response beat valid. There is no backpressure.
- `mem_rsp_data_i` in BEAT_WIDTH: response beat.
- `req_o` out ICACHE_N_WAY: one-hot way select to the data memory.
- `we_o` out 1: write enable to the data memory.
- `addr_o` out ADDR_WIDHT: write set index.
- `data_o` out SET_WIDHT: assembled line.
- `done_o` out 1: one-cycle pulse when the line is written.
- `done_way_o` out $clog2(ICACHE_N_WAY): victim way index, valid with `done_o`; used by the tag memory.
- `busy_o` out 1: high whenever the controller is not in IDLE.

## Operation
- FSM states are IDLE, REQ, FILL and WRITE.
- **IDLE**
  - `miss_ready_o=1`.
  - On `miss_valid_i`:
    - latch the index;
    - latch the victim way;
    - clear the beat counter and the drop flag;
    - go to REQ.
- **Victim selection**
  - Choose the lowest-index way with `valid_bits_i` = 0.
  - If all ways are valid, choose the way given by the round-robin pointer, then increment the pointer modulo ICACHE_N_WAY.
  - The pointer changes only on an all-valid eviction.
- **REQ**
  - `mem_req_valid_o=1` and is held until `mem_req_ready_i`. The index is stable throughout.
  - On handshake, go to FILL.
- **FILL**
  - Each `mem_rsp_valid_i` writes beat k into line bits [k*BEAT_WIDTH +: BEAT_WIDTH], then k increments.
  - On beat N_BEATS-1:
    - drop flag clear: go to WRITE;
    - drop flag set: go to IDLE.
- **WRITE** (exactly one cycle), then go to IDLE:
  - `req_o` = one-hot victim;
  - `we_o=1`;
  - `addr_o` = latched index;
  - `done_o=1`;
  - `done_way_o` = victim.
- Outside WRITE, `req_o=0`, `we_o=0` and `done_o=0`.
- `data_o` and `addr_o` are driven from the registered line buffer and latched index at all times.
- `mem_rsp_valid_i` outside FILL is ignored.
- **Flush**
  - In REQ without a same-cycle handshake: go to IDLE next cycle. No memory request has been issued.
  - In REQ with a same-cycle handshake, or in FILL: set the drop flag. Remaining beats are consumed, the write is suppressed and `done_o` is not asserted.
  - In WRITE: the write still completes.
  - In IDLE: no effect.
- A miss is not accepted while `flush_i` is high.

## Timing
- **Reset** (asynchronous, immediate, any state):
  - state IDLE, so `miss_ready_o=1`;
  - every other output 0;
  - line buffer, index, beat counter, drop flag and round-robin pointer all cleared.
- **Latency**
  - Miss accepted at cycle 0.
  - `mem_req_valid_o` rises at cycle 1.
  - Handshake at cycle h leads to FILL at h+1.
  - Last beat at cycle t leads to WRITE/`done_o` at t+1 and IDLE (`miss_ready_o=1`) at t+2.
  - Minimum miss-to-write with N_BEATS=4, immediate ready and back-to-back beats: 7 cycles.
- The next miss can be accepted at t+2. There is no miss accepted in the WRITE cycle.
- Beats may arrive with arbitrary gaps; the counter holds while `mem_rsp_valid_i`=0.
- Reset mid-FILL discards the partial line. No write occurs.

## Test plan
- Miss idx=5 with valid_bits=4'b1011, grant immediately, then 4 beats 0x11..,0x22..,0x33..,0x44.. back-to-back:
  - WRITE at cycle 7 with `req_o=4'b0100`, `addr_o=5`;
  - `data_o`={0x44..,0x33..,0x22..,0x11..};
  - `done_way_o=2`.
- Three consecutive misses, all with valid_bits=4'b1111 -> victims are ways 0, 1, 2 in order. A fourth miss with valid_bits=4'b0111 -> victim way 3 and the pointer stays at 3.
- `mem_req_ready_i` held low for 5 cycles -> `mem_req_valid_o` stays high and `mem_req_idx_o` stays stable. FILL is entered the cycle after ready. Beats with 2-cycle gaps still assemble correctly.
- `flush_i` during FILL after beat 1 -> beats 2 and 3 are consumed, `we_o` and `done_o` stay 0, and IDLE is reached the cycle after beat 3. `flush_i` in REQ without grant -> IDLE next cycle and no handshake.
- `rst_i` asserted mid-FILL -> immediately `busy_o=0`, `miss_ready_o=1`, and `data_o`, `req_o`, `we_o` all 0. A new miss after reset sees round-robin pointer 0.
